// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one word-wide memory port between fetch and load/store.
// Sub-word stores are read-modify-write sequences; all responses are registered one-cycle pulses.
module mem_arbiter #(
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
  parameter logic [AWIDTH-1:0] MEM_BYTES = 32'h00100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, READ, RMW_RD, WRITE} state_t;

  state_t            state_q, state_d;
  logic              prio_d_q, prio_d_d;   // 1: data side wins the next tie
  logic              id_q, id_d;           // 1: data requester owns the access
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DWIDTH-1:0] if_rdata_q, if_rdata_d;
  logic              if_err_q, if_err_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_data_q, mem_data_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;

  logic              gnt_if, gnt_d;
  logic [AWIDTH-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic              sel_we;
  logic              in_range, size_err, req_err;
  logic [DWIDTH-1:0] shifted, load_val, merged;

  always_comb begin
    gnt_d    = rst && (state_q == IDLE) && d_req_i && (!if_req_i || prio_d_q);
    gnt_if   = rst && (state_q == IDLE) && if_req_i && (!d_req_i || !prio_d_q);
    sel_addr = gnt_d ? d_addr_i : if_addr_i;
    sel_size = gnt_d ? d_size_i : 2'b10;
    sel_we   = gnt_d && d_we_i;
    in_range = (sel_addr >= BASE_ADDR) && ((sel_addr - BASE_ADDR) < MEM_BYTES);
    case (sel_size)
      2'b00:   size_err = 1'b0;
      2'b01:   size_err = sel_addr[0];
      2'b10:   size_err = |sel_addr[1:0];
      default: size_err = 1'b1;
    endcase
    req_err = !in_range || size_err;
  end

  always_comb begin
    shifted = mem_data_i >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {24'd0, shifted[7:0]};
      2'b01:   load_val = {16'd0, shifted[15:0]};
      default: load_val = mem_data_i;
    endcase
    merged = mem_data_i;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d     = state_q;
    prio_d_d    = prio_d_q;
    id_d        = id_q;
    lane_d      = lane_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_d || gnt_if) begin
          prio_d_d = gnt_if;
          id_d     = gnt_d;
          lane_d   = sel_addr[1:0];
          size_d   = sel_size;
          wdata_d  = d_wdata_i[15:0];
          if (req_err) begin
            // Rejected accesses answer next cycle without touching memory.
            if (gnt_d) begin
              d_rvalid_d = 1'b1;
              d_err_d    = 1'b1;
              d_rdata_d  = '0;
            end else begin
              if_rvalid_d = 1'b1;
              if_err_d    = 1'b1;
              if_rdata_d  = '0;
            end
          end else begin
            mem_addr_d = {sel_addr[AWIDTH-1:2], 2'b00};
            if (!sel_we) begin
              state_d = READ;
              rd_en_d = 1'b1;
            end else if (sel_size == 2'b10) begin
              state_d    = WRITE;
              wr_en_d    = 1'b1;
              mem_data_d = d_wdata_i;
            end else begin
              state_d = RMW_RD;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      READ: begin
        state_d = IDLE;
        if (id_q) begin
          d_rvalid_d = 1'b1;
          d_err_d    = 1'b0;
          d_rdata_d  = load_val;
        end else begin
          if_rvalid_d = 1'b1;
          if_err_d    = 1'b0;
          if_rdata_d  = load_val;
        end
      end
      RMW_RD: begin
        state_d    = WRITE;
        wr_en_d    = 1'b1;
        mem_data_d = merged;
      end
      WRITE: begin
        state_d    = IDLE;
        d_rvalid_d = 1'b1;
        d_err_d    = 1'b0;
        d_rdata_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prio_d_q    <= 1'b1;
      id_q        <= 1'b0;
      lane_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_data_q  <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_d_q    <= prio_d_d;
      id_q        <= id_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign if_gnt_o       = gnt_if;
  assign d_gnt_o        = gnt_d;
  assign if_rvalid_o    = if_rvalid_q;
  assign if_rdata_o     = if_rdata_q;
  assign if_err_o       = if_err_q;
  assign d_rvalid_o     = d_rvalid_q;
  assign d_rdata_o      = d_rdata_q;
  assign d_err_o        = d_err_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;
  assign mem_read_en_o  = rd_en_q;
  assign mem_write_en_o = wr_en_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer in front of the byte-addressable `memory` block. It shares the single memory port between the instruction-fetch requester and the load/store requester, converts every access to a word-aligned memory transaction, performs read-modify-write for byte and halfword stores, and returns read data or an error per requester over a req/gnt/rvalid handshake.

## Interface
- `AWIDTH`, 32, address width (all address ports)
- `DWIDTH`, 32, data width; fixed at 32
- `BASE_ADDR`, 32'h01000000, first byte address of memory
- `MEM_BYTES`, 32'h00100000, memory size in bytes; valid range is BASE_ADDR .. BASE_ADDR+MEM_BYTES-1

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch request
- `if_addr_i`  in  AWIDTH  fetch byte address
- `if_gnt_o`  out  1  fetch request accepted this cycle
- `if_rvalid_o`  out  1  fetch response valid, one-cycle pulse
- `if_rdata_o`  out  32  fetch word
- `if_err_o`  out  1  fetch error, valid with if_rvalid_o
- `d_req_i`  in  1  data request
- `d_we_i`  in  1  1 = store, 0 = load
- `d_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- `d_addr_i`  in  AWIDTH  data byte address
- `d_wdata_i`  in  32  store data, LSB-aligned
- `d_gnt_o`  out  1  data request accepted this cycle
- `d_rvalid_o`  out  1  data response (load data or store ack), one-cycle pulse
- `d_rdata_o`  out  32  load data, zero-extended; 0 for stores
- `d_err_o`  out  1  data error, valid with d_rvalid_o
- `mem_addr_o`  out  AWIDTH  word-aligned address to memory
- `mem_data_o`  out  32  write data to memory
- `mem_read_en_o`  out  1  memory read enable
- `mem_write_en_o`  out  1  memory write enable
- `mem_data_i`  in  32  combinational memory read data

## Operation
- States: IDLE, READ, RMW_RD, WRITE.
- IDLE: at most one grant per cycle; gnt is combinational from req, only in IDLE. Both requesting: grant the requester not granted last (round-robin pointer); after reset, data wins first tie.
- On grant edge capture requester id, addr, size, we, wdata. Requester holds req/addr/data stable until gnt; may present a new request the cycle after gnt.
- Error check at grant: addr outside valid range; fetch addr[1:0]≠0; data half with addr[0]=1; word with addr[1:0]≠0; size 11. Error: no memory access, state stays IDLE, rvalid+err next cycle, rdata 0.
- Load/fetch → READ: mem_addr_o = {addr[31:2],2'b00}, mem_read_en_o=1; capture mem_data_i at end of cycle. Byte: lane addr[1:0]; half: lane addr[1]; zero-extend. → IDLE.
- Word store → WRITE: mem_data_o = wdata, mem_write_en_o=1; memory updates at end of cycle. → IDLE.
- Byte/half store → RMW_RD (read aligned word, merge wdata[7:0]/[15:0] into selected lane, register) → WRITE with merged word → IDLE.
- Memory outputs: enables 0 in IDLE; mem_addr_o/mem_data_o hold last value.

## Timing
- Grant at cycle T. Load/fetch: READ T+1, rvalid T+2. Word store: WRITE T+1, ack T+2. Sub-word store: RMW_RD T+1, WRITE T+2, ack T+3. Error: rvalid+err T+1.
- State returns to IDLE in the cycle rvalid is high; a new grant may coincide with rvalid of the previous access. Peak throughput: one word access per 2 cycles.
- rvalid pulses exactly one cycle; rdata/err valid only with rvalid, then hold.
- Reset (rst=0, async): state IDLE, pointer favors data, all gnt/rvalid/err/enables 0, rdata 0, mem_data_o 0, mem_addr_o BASE_ADDR. Reset mid-WRITE drops write_en immediately; the write does not occur. No response for aborted accesses.

## Test plan
- Preload 0x01000000 = 0xDEADBEEF; fetch 0x01000000 at T → if_gnt T, if_rvalid T+2 with 0xDEADBEEF, if_err 0.
- Load byte 0x01000001 and half 0x01000002 → d_rdata 0x000000BE, then 0x0000DEAD.
- Store byte 0x55 to 0x01000002 → RMW_RD at T+1, write 0xDE55BEEF at T+2, ack T+3; word reload returns 0xDE55BEEF.
- if_req and d_req both held high from reset → grants alternate D, I, D, I; no requester starved.
- Word load 0x01000002, half store 0x01000001, fetch 0x00FFFFFC, size 11 → each rvalid+err at T+1, mem enables never asserted.
- Assert rst during WRITE of 0x12345678 → enables drop at once; memory word unchanged; no d_rvalid.
